// File: rtl/gpio_timer_regbank.sv
// GPIO and timer control/status register bank with a registered read port.
// GPIO interrupts are edge-detected and W1C; NUM_TIMERS counters run in-block. ADDR_W must be >= 5.
module gpio_timer_regbank #(
    parameter int GPIO_W     = 16,
    parameter int NUM_TIMERS = 2,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              r_wn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wben,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [GPIO_W-1:0] gpio_pins_in,
    output logic [GPIO_W-1:0] gpio_data_out,
    output logic [GPIO_W-1:0] gpio_tristate_out,
    output logic              irq
);
    localparam logic [31:0] CNAME_VAL    = 32'h4852_4A44;
    localparam logic [31:0] CVERSION_VAL = 32'h0002_0000;

    typedef enum logic {T_IDLE, T_RUN} tstate_e;

    logic              wr_en, rd_en;
    logic [31:0]       lane_mask, clr_bits;
    logic [ADDR_W-1:0] t_off;
    logic [31:0]       t_idx;
    logic              in_timer;

    assign wr_en     = req & ~r_wn;
    assign rd_en     = req & r_wn;
    assign lane_mask = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
    assign clr_bits  = wdata & lane_mask;
    // Timer windows are 4-word aligned above word 16
    assign t_off     = addr - ADDR_W'(16);
    assign t_idx     = 32'(t_off[ADDR_W-1:2]);
    assign in_timer  = (addr >= ADDR_W'(16)) && (t_idx < 32'(NUM_TIMERS));

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    logic [GPIO_W-1:0] tristate_q, imask_q, data_q, iedge_q, istatus_q, istatus_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q, prev_q, edge_hit;
    logic [31:0]       scratch_q;
    logic              wr_istatus;

    assign wr_istatus = wr_en && (addr == ADDR_W'(8));
    assign edge_hit   = (sync2_q & ~prev_q & ~iedge_q) | (~sync2_q & prev_q & iedge_q);
    // Hardware set is OR-ed after the clear so a coincident edge survives
    assign istatus_d  = (istatus_q & ~(wr_istatus ? GPIO_W'(clr_bits) : '0)) | edge_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            tristate_q <= '0;
            imask_q    <= '0;
            data_q     <= '0;
            iedge_q    <= '0;
            istatus_q  <= '0;
            scratch_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
        end else begin
            if (wr_en && addr == ADDR_W'(2)) tristate_q <= GPIO_W'(merge(32'(tristate_q), wdata, lane_mask));
            if (wr_en && addr == ADDR_W'(4)) imask_q    <= GPIO_W'(merge(32'(imask_q), wdata, lane_mask));
            if (wr_en && addr == ADDR_W'(5)) data_q     <= GPIO_W'(merge(32'(data_q), wdata, lane_mask));
            if (wr_en && addr == ADDR_W'(6)) scratch_q  <= merge(scratch_q, wdata, lane_mask);
            if (wr_en && addr == ADDR_W'(7)) iedge_q    <= GPIO_W'(merge(32'(iedge_q), wdata, lane_mask));
            istatus_q <= istatus_d;
            sync1_q   <= gpio_pins_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    logic [31:0]           t_word_w [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] t_sel_w, t_irq_w;

    generate
        for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
            tstate_e     state_q, state_d;
            logic [31:0] term_q, curr_q, curr_d, word;
            logic        mode_q, ien_q, done_q, done_set;
            logic        sel, wr_ctrl, start, halt, w1c_done;

            assign sel      = in_timer && (t_idx == 32'(gi));
            assign wr_ctrl  = wr_en && sel && (t_off[1:0] == 2'd0) && wben[0];
            assign start    = wr_ctrl && wdata[0];
            assign halt     = wr_ctrl && wdata[1];
            assign w1c_done = wr_en && sel && (t_off[1:0] == 2'd3) && wben[0] && wdata[0];

            always_comb begin
                state_d  = state_q;
                curr_d   = curr_q;
                done_set = 1'b0;
                if (state_q == T_RUN) begin
                    if (curr_q == term_q) begin
                        done_set = 1'b1;
                        if (mode_q) curr_d = '0;
                        else        state_d = T_IDLE;
                    end else begin
                        curr_d = curr_q + 32'd1;
                    end
                end
                if (halt) begin
                    state_d = T_IDLE;
                    curr_d  = curr_q;
                end else if (start) begin
                    state_d = T_RUN;
                    curr_d  = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= T_IDLE;
                    curr_q  <= '0;
                    term_q  <= '0;
                    mode_q  <= 1'b0;
                    ien_q   <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    curr_q  <= curr_d;
                    done_q  <= (done_q & ~w1c_done) | done_set;
                    if (wr_ctrl) begin
                        mode_q <= wdata[2];
                        ien_q  <= wdata[3];
                    end
                    if (wr_en && sel && t_off[1:0] == 2'd1) term_q <= merge(term_q, wdata, lane_mask);
                end
            end

            always_comb begin
                case (t_off[1:0])
                    2'd0:    word = {28'd0, ien_q, mode_q, 2'b00};
                    2'd1:    word = term_q;
                    2'd2:    word = curr_q;
                    default: word = {30'd0, (state_q == T_RUN), done_q};
                endcase
            end

            assign t_word_w[gi] = word;
            assign t_sel_w[gi]  = sel;
            assign t_irq_w[gi]  = done_q & ien_q;
        end
    endgenerate

    logic [31:0] rd_word, rdata_q;
    logic        rvalid_q, irq_q;

    always_comb begin
        rd_word = '0;
        if (in_timer) begin
            for (int k = 0; k < NUM_TIMERS; k++) begin
                if (t_sel_w[k]) rd_word = t_word_w[k];
            end
        end else begin
            case (addr)
                ADDR_W'(0): rd_word = CNAME_VAL;
                ADDR_W'(1): rd_word = CVERSION_VAL;
                ADDR_W'(2): rd_word = 32'(tristate_q);
                ADDR_W'(3): rd_word = 32'(sync2_q);
                ADDR_W'(4): rd_word = 32'(imask_q);
                ADDR_W'(5): rd_word = 32'(data_q);
                ADDR_W'(6): rd_word = scratch_q;
                ADDR_W'(7): rd_word = 32'(iedge_q);
                ADDR_W'(8): rd_word = 32'(istatus_q);
                default:    rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) rdata_q <= rd_word;
            irq_q <= (|(istatus_q & imask_q)) | (|t_irq_w);
        end
    end

    assign rdata             = rdata_q;
    assign rvalid            = rvalid_q;
    assign irq               = irq_q;
    assign gpio_data_out     = data_q;
    assign gpio_tristate_out = tristate_q;
endmodule

// File: tb/tb_gpio_timer_regbank.sv
// Directed bench for gpio_timer_regbank: a register-level reference model checked
// every cycle, plus hand-computed read expectations.
module tb_gpio_timer_regbank;
    localparam int GPIO_W     = 16;
    localparam int NUM_TIMERS = 2;
    localparam int ADDR_W     = 5;
    localparam logic [31:0] GMASK = 32'h0000_FFFF;

    logic              clk = 1'b0;
    logic              reset, req, r_wn;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wben;
    logic [31:0]       wdata, rdata;
    logic              rvalid, irq;
    logic [GPIO_W-1:0] gpio_pins_in, gpio_data_out, gpio_tristate_out;

    always #5 clk = ~clk;

    gpio_timer_regbank #(.GPIO_W(GPIO_W), .NUM_TIMERS(NUM_TIMERS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req), .r_wn(r_wn), .addr(addr), .wben(wben),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .gpio_pins_in(gpio_pins_in),
        .gpio_data_out(gpio_data_out), .gpio_tristate_out(gpio_tristate_out), .irq(irq)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: register contents, pin sample history and timers as plain records
    typedef struct {
        bit          running;
        bit          periodic;
        bit          ien;
        bit          done;
        logic [31:0] term;
        logic [31:0] curr;
    } tmr_t;

    tmr_t        tm [NUM_TIMERS];
    logic [31:0] m_tri, m_imask, m_data, m_scratch, m_iedge, m_istat;
    logic [31:0] pin_hist [3];
    logic [31:0] m_rdata;
    bit          m_rvalid, m_irq;

    function automatic logic [31:0] model_read(input int a);
        int n;
        int r;
        if (a >= 16) begin
            n = (a - 16) / 4;
            r = (a - 16) % 4;
            if (n >= NUM_TIMERS) return 32'd0;
            case (r)
                0:       return {28'd0, tm[n].ien, tm[n].periodic, 2'b00};
                1:       return tm[n].term;
                2:       return tm[n].curr;
                default: return {30'd0, tm[n].running, tm[n].done};
            endcase
        end
        case (a)
            0:       return 32'h4852_4A44;
            1:       return 32'h0002_0000;
            2:       return m_tri;
            3:       return pin_hist[1];
            4:       return m_imask;
            5:       return m_data;
            6:       return m_scratch;
            7:       return m_iedge;
            8:       return m_istat;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] lanes_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [31:0] l);
        return (o & ~l) | (n & l);
    endfunction

    always @(posedge clk) begin
        int          a;
        int          base;
        bit          is_wr;
        logic [31:0] lanes, rise, fall, old_curr;
        if (reset) begin
            m_tri = 0; m_imask = 0; m_data = 0; m_scratch = 0; m_iedge = 0; m_istat = 0;
            m_rdata = 0; m_rvalid = 0; m_irq = 0;
            for (int k = 0; k < 3; k++) pin_hist[k] = 0;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                tm[n].running = 0; tm[n].periodic = 0; tm[n].ien = 0; tm[n].done = 0;
                tm[n].term = 0; tm[n].curr = 0;
            end
        end else begin
            a     = int'(addr);
            is_wr = req && !r_wn;
            lanes = 0;
            for (int k = 0; k < 4; k++) if (wben[k]) lanes |= 32'hFF << (8 * k);
            m_rvalid = req && r_wn;
            if (m_rvalid) m_rdata = model_read(a);
            m_irq = (m_istat & m_imask) != 0;
            for (int n = 0; n < NUM_TIMERS; n++) if (tm[n].done && tm[n].ien) m_irq = 1;
            if (is_wr && a == 8) m_istat &= ~(wdata & lanes);
            rise = pin_hist[1] & ~pin_hist[2];
            fall = ~pin_hist[1] & pin_hist[2];
            m_istat |= ((rise & ~m_iedge) | (fall & m_iedge)) & GMASK;
            pin_hist[2] = pin_hist[1];
            pin_hist[1] = pin_hist[0];
            pin_hist[0] = 32'(gpio_pins_in);
            for (int n = 0; n < NUM_TIMERS; n++) begin
                base     = 16 + 4 * n;
                old_curr = tm[n].curr;
                if (is_wr && a == base + 3 && wben[0] && wdata[0]) tm[n].done = 0;
                if (tm[n].running) begin
                    if (tm[n].curr == tm[n].term) begin
                        tm[n].done = 1;
                        if (tm[n].periodic) tm[n].curr = 0;
                        else tm[n].running = 0;
                    end else begin
                        tm[n].curr = tm[n].curr + 32'd1;
                    end
                end
                if (is_wr && a == base && wben[0]) begin
                    if (wdata[1]) begin
                        tm[n].running = 0;
                        tm[n].curr = old_curr;
                    end else if (wdata[0]) begin
                        tm[n].running = 1;
                        tm[n].curr = 0;
                    end
                    tm[n].periodic = wdata[2];
                    tm[n].ien = wdata[3];
                end
                if (is_wr && a == base + 1) tm[n].term = lanes_merge(tm[n].term, wdata, lanes);
            end
            if (is_wr) begin
                case (a)
                    2: m_tri     = lanes_merge(m_tri, wdata, lanes) & GMASK;
                    4: m_imask   = lanes_merge(m_imask, wdata, lanes) & GMASK;
                    5: m_data    = lanes_merge(m_data, wdata, lanes) & GMASK;
                    6: m_scratch = lanes_merge(m_scratch, wdata, lanes);
                    7: m_iedge   = lanes_merge(m_iedge, wdata, lanes) & GMASK;
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", rdata, m_rdata);
        chk("irq", 32'(irq), 32'(m_irq));
        chk("gpio_data_out", 32'(gpio_data_out), m_data);
        chk("gpio_tristate_out", 32'(gpio_tristate_out), m_tri);
    end

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        req = 1'b1; r_wn = 1'b0; addr = ADDR_W'(a); wdata = d; wben = be;
        @(negedge clk);
        req = 1'b0;
        $display("[TB] write addr=%0d data=0x%08h wben=%b", a, d, be);
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        req = 1'b1; r_wn = 1'b1; addr = ADDR_W'(a);
        @(posedge clk);
        #1;
        chk(name, rdata, exp);
        chk({name, " rvalid"}, 32'(rvalid), 32'd1);
        $display("[TB] read  addr=%0d data=0x%08h (%s)", a, rdata, name);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 1'b0; r_wn = 1'b0; addr = '0; wben = '0; wdata = '0;
        gpio_pins_in = '0;
        idle(3);
        chk("reset rdata", rdata, 32'd0);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        reset = 1'b0;

        rd(0, 32'h4852_4A44, "CNAME");
        rd(1, 32'h0002_0000, "CVERSION");
        rd(3, 32'h0000_0000, "PINSTATE zero");

        wr(5, 32'hFFFF_FFFF, 4'b0001);
        rd(5, 32'h0000_00FF, "DATA lane0");
        wr(6, 32'hA5A5_A5A5, 4'b1010);
        rd(6, 32'hA500_A500, "SCRATCH lanes");
        wr(5, 32'hFFFF_FFFF, 4'b1111);
        rd(5, 32'h0000_FFFF, "DATA upper bits");
        chk("gpio_data_out full", 32'(gpio_data_out), 32'h0000_FFFF);
        wr(2, 32'h1234_F0F0, 4'b1111);
        rd(2, 32'h0000_F0F0, "TRISTATE");
        wr(0, 32'h0000_0000, 4'b1111);
        rd(0, 32'h4852_4A44, "CNAME read-only");
        rd(9, 32'd0, "unmapped word");
        rd(24, 32'd0, "absent timer");

        wr(7, 32'd0, 4'b1111);
        wr(4, 32'd1, 4'b1111);
        gpio_pins_in = 16'h0001;
        repeat (3) @(posedge clk);
        #1 chk("irq before latency", 32'(irq), 32'd0);
        @(posedge clk);
        #1 chk("irq after edge", 32'(irq), 32'd1);
        @(negedge clk);
        rd(8, 32'd1, "ISTATUS rise");
        wr(8, 32'd1, 4'b1111);
        rd(8, 32'd0, "ISTATUS w1c");
        chk("irq after w1c", 32'(irq), 32'd0);
        gpio_pins_in = 16'h0000;
        idle(5);
        gpio_pins_in = 16'h0001;
        idle(2);
        wr(8, 32'd1, 4'b1111);
        rd(8, 32'd1, "ISTATUS set wins");
        wr(8, 32'd1, 4'b1111);
        wr(7, 32'd1, 4'b1111);
        gpio_pins_in = 16'h0000;
        idle(5);
        rd(8, 32'd1, "ISTATUS falling");
        wr(8, 32'd1, 4'b1111);
        wr(4, 32'd0, 4'b1111);
        gpio_pins_in = 16'hA5C3;
        idle(4);
        rd(3, 32'h0000_A5C3, "PINSTATE sync");

        wr(17, 32'd3, 4'b1111);
        wr(16, 32'h1, 4'b1111);
        rd(18, 32'd0, "T0 CURR 0");
        rd(18, 32'd1, "T0 CURR 1");
        rd(18, 32'd2, "T0 CURR 2");
        rd(18, 32'd3, "T0 CURR 3");
        rd(19, 32'd1, "T0 done not running");
        rd(18, 32'd3, "T0 CURR holds");

        wr(21, 32'd2, 4'b1111);
        wr(20, 32'hD, 4'b1111);
        rd(22, 32'd0, "T1 CURR 0");
        rd(22, 32'd1, "T1 CURR 1");
        rd(22, 32'd2, "T1 CURR 2");
        rd(22, 32'd0, "T1 CURR reload");
        rd(23, 32'd3, "T1 done running");
        chk("irq timer1", 32'(irq), 32'd1);
        wr(23, 32'd1, 4'b1111);
        idle(1);
        wr(20, 32'hE, 4'b1111);
        rd(22, 32'd1, "T1 CURR halted");
        rd(23, 32'd1, "T1 done set wins, idle");
        rd(22, 32'd1, "T1 CURR frozen");
        wr(20, 32'h3, 4'b1111);
        rd(23, 32'd1, "T1 start+halt idle");
        chk("irq ien cleared", 32'(irq), 32'd0);

        wr(20, 32'hD, 4'b1111);
        idle(5);
        chk("irq before reset", 32'(irq), 32'd1);
        reset = 1'b1; req = 1'b1; r_wn = 1'b1; addr = ADDR_W'(22);
        @(posedge clk);
        #1;
        chk("reset rvalid forced", 32'(rvalid), 32'd0);
        chk("reset irq cleared", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        rd(22, 32'd0, "T1 CURR after reset");
        rd(23, 32'd0, "T1 TSTAT after reset");
        rd(21, 32'd0, "T1 TERM after reset");
        rd(5, 32'd0, "DATA after reset");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
